// File: rtl/sram_sdp_init.sv
// ============================================================================
//  Module      : sram_sdp_init
//  Description : Simple-dual-port SRAM simulation model with per-lane write
//                masking, a selectable read-during-write policy, a read-valid
//                strobe and a post-reset zeroing sweep that brings the array
//                up with deterministic contents.
//                Optional feature macro: SRAM_OREG_EN (adds a second output
//                register stage, read latency 2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_sdp_init #(
    parameter int SIZE = 4,   // depth = 2**SIZE words
    parameter int WLEN = 32,  // word length in bits
    parameter int STEP = 2,   // 2**STEP write lanes
    parameter int FWD  = 1    // same-address read during write: 1 new, 0 old
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    output logic                   READY,
    input  logic                   CENA,
    input  logic [SIZE-1:0]        AA,
    output logic [WLEN-1:0]        QA,
    output logic                   QVA,
    input  logic                   CENB,
    input  logic [(1<<STEP)-1:0]   WENB,
    input  logic [SIZE-1:0]        AB,
    input  logic [WLEN-1:0]        DB
);

    localparam int LANES = 1 << STEP;
    localparam int WIDTH = WLEN >> STEP;
    localparam int DEPTH = 1 << SIZE;

    // Reject geometries that cannot be built.
    generate
        if (SIZE < 1 || (WLEN % LANES) != 0) begin : g_bad_cfg
            $fatal(1, "sram_sdp_init: SIZE must be >= 1 and WLEN a multiple of 2**STEP");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SIZE-1:0]     cnt_q, cnt_d;
    logic [WLEN-1:0]     mem_q [DEPTH];

    logic                w_rd_en;
    logic                w_wr_en;
    logic                w_collide;
    logic [WLEN-1:0]     w_wr_old;
    logic [WLEN-1:0]     w_wr_word;
    logic [WLEN-1:0]     w_rd_word;

    logic [WLEN-1:0]     rd_q;
    logic                rdv_q;

    // Ports are only honoured once the sweep has finished.
    assign READY     = (state_q == ST_RUN);
    assign w_rd_en   = READY && !CENA;
    assign w_wr_en   = READY && !CENB && (WENB != {LANES{1'b1}});
    assign w_collide = w_wr_en && (AA == AB);
    assign w_wr_old  = mem_q[AB];

    // Merge enabled lanes of DB over the current word at AB.
    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            assign w_wr_word[j*WIDTH +: WIDTH] = WENB[j] ? w_wr_old[j*WIDTH +: WIDTH]
                                                         : DB[j*WIDTH +: WIDTH];
        end
    endgenerate

    // Forwarding is decided in the access cycle, independent of output staging.
    assign w_rd_word = (FWD != 0 && w_collide) ? w_wr_word : mem_q[AA];

    // State and sweep counter register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep advances one word per cycle; RUN is terminal until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {SIZE{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Array: zeroed by the sweep, then written lane-merged by port B.
    always_ff @(posedge CLK) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (w_wr_en) begin
            mem_q[AB] <= w_wr_word;
        end
    end

    // Read capture stage; data holds between accepted reads.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_q  <= '0;
            rdv_q <= 1'b0;
        end else begin
            rdv_q <= w_rd_en;
            if (w_rd_en) begin
                rd_q <= w_rd_word;
            end
        end
    end

`ifdef SRAM_OREG_EN
    logic [WLEN-1:0] oreg_q;
    logic            oregv_q;

    // Extra output stage: delays data and valid by one more cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            oreg_q  <= '0;
            oregv_q <= 1'b0;
        end else begin
            oregv_q <= rdv_q;
            if (rdv_q) begin
                oreg_q <= rd_q;
            end
        end
    end

    assign QA  = oreg_q;
    assign QVA = oregv_q;
`else
    assign QA  = rd_q;
    assign QVA = rdv_q;
`endif

endmodule

`default_nettype wire
